// File: rtl/range_parser.sv
// ASCII "lo-hi," range parser: converts decimal bound pairs to binary values plus
// significant-digit counts, dropping malformed ranges with a one-cycle err pulse.
module range_parser #(
   parameter int W          = 32,
   parameter int LW         = 4,
   parameter int MAX_DIGITS = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    in_byte,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [W-1:0]  lo_val,
   output logic [LW-1:0] lo_len,
   output logic [W-1:0]  hi_val,
   output logic [LW-1:0] hi_len,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          err
);

   localparam int XW = W + 4;

   typedef enum logic [1:0] {
      ST_LO   = 2'd0,
      ST_HI   = 2'd1,
      ST_SKIP = 2'd2,
      ST_EMIT = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  acc_q, acc_d;
   logic [LW-1:0] len_q, len_d;
   logic          seen_q, seen_d;
   logic [W-1:0]  lo_hold_q, lo_hold_d;
   logic [LW-1:0] lo_hold_len_q, lo_hold_len_d;
   logic [W-1:0]  lo_val_q, lo_val_d;
   logic [LW-1:0] lo_len_q, lo_len_d;
   logic [W-1:0]  hi_val_q, hi_val_d;
   logic [LW-1:0] hi_len_q, hi_len_d;
   logic          out_valid_q, out_valid_d;
   logic          err_q, err_d;

   logic          take_s;
   logic          is_digit_s, is_term_s, is_dash_s;
   logic [XW-1:0] acc_x_s, wide_s;
   logic          count_s, ovf_s, fault_s;
   logic [LW-1:0] len_inc_s, fin_len_s;

   assign in_ready  = (state_q != ST_EMIT);
   assign lo_val    = lo_val_q;
   assign lo_len    = lo_len_q;
   assign hi_val    = hi_val_q;
   assign hi_len    = hi_len_q;
   assign out_valid = out_valid_q;
   assign err       = err_q;

   // Byte classification and the shared digit-accumulate datapath.
   always_comb begin
      take_s     = in_valid && in_ready;
      is_digit_s = (in_byte >= 8'h30) && (in_byte <= 8'h39);
      is_term_s  = (in_byte == 8'h2C) || (in_byte == 8'h0A);
      is_dash_s  = (in_byte == 8'h2D);
      acc_x_s    = XW'(acc_q);
      wide_s     = (acc_x_s << 3) + (acc_x_s << 1) + XW'(in_byte[3:0]);
      count_s    = (acc_q != {W{1'b0}}) || (in_byte[3:0] != 4'd0);
      len_inc_s  = count_s ? (len_q + LW'(1)) : len_q;
      ovf_s      = (|wide_s[XW-1:W]) || (count_s && (len_q >= LW'(MAX_DIGITS)));
      // A field of only zeros still occupies one digit.
      fin_len_s  = (len_q == {LW{1'b0}}) ? LW'(1) : len_q;
   end

   // Next-state and datapath decisions for the parse FSM.
   always_comb begin
      state_d       = state_q;
      acc_d         = acc_q;
      len_d         = len_q;
      seen_d        = seen_q;
      lo_hold_d     = lo_hold_q;
      lo_hold_len_d = lo_hold_len_q;
      lo_val_d      = lo_val_q;
      lo_len_d      = lo_len_q;
      hi_val_d      = hi_val_q;
      hi_len_d      = hi_len_q;
      out_valid_d   = out_valid_q;
      err_d         = 1'b0;
      fault_s       = 1'b0;

      case (state_q)
         ST_LO, ST_HI: begin
            if (take_s) begin
               if (is_digit_s) begin
                  if (ovf_s) begin
                     fault_s = 1'b1;
                  end else begin
                     acc_d  = wide_s[W-1:0];
                     len_d  = len_inc_s;
                     seen_d = 1'b1;
                  end
               end else if (is_dash_s && (state_q == ST_LO) && seen_q) begin
                  lo_hold_d     = acc_q;
                  lo_hold_len_d = fin_len_s;
                  acc_d         = {W{1'b0}};
                  len_d         = {LW{1'b0}};
                  seen_d        = 1'b0;
                  state_d       = ST_HI;
               end else if (is_term_s && (state_q == ST_HI) && seen_q) begin
                  lo_val_d    = lo_hold_q;
                  lo_len_d    = lo_hold_len_q;
                  hi_val_d    = acc_q;
                  hi_len_d    = fin_len_s;
                  out_valid_d = 1'b1;
                  acc_d       = {W{1'b0}};
                  len_d       = {LW{1'b0}};
                  seen_d      = 1'b0;
                  state_d     = ST_EMIT;
               end else if (is_term_s && (state_q == ST_LO) && !seen_q) begin
                  state_d = ST_LO;
               end else begin
                  fault_s = 1'b1;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_SKIP: begin
            if (take_s && is_term_s) begin
               state_d = ST_LO;
            end else begin
               state_d = ST_SKIP;
            end
         end
         ST_EMIT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_LO;
            end else begin
               state_d = ST_EMIT;
            end
         end
         default: begin
            state_d = ST_LO;
         end
      endcase

      // A terminator that faults has already closed its range, so it skips SKIP.
      if (fault_s) begin
         err_d   = 1'b1;
         acc_d   = {W{1'b0}};
         len_d   = {LW{1'b0}};
         seen_d  = 1'b0;
         state_d = is_term_s ? ST_LO : ST_SKIP;
      end else begin
         err_d = 1'b0;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_LO;
         acc_q         <= {W{1'b0}};
         len_q         <= {LW{1'b0}};
         seen_q        <= 1'b0;
         lo_hold_q     <= {W{1'b0}};
         lo_hold_len_q <= {LW{1'b0}};
         lo_val_q      <= {W{1'b0}};
         lo_len_q      <= {LW{1'b0}};
         hi_val_q      <= {W{1'b0}};
         hi_len_q      <= {LW{1'b0}};
         out_valid_q   <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         acc_q         <= acc_d;
         len_q         <= len_d;
         seen_q        <= seen_d;
         lo_hold_q     <= lo_hold_d;
         lo_hold_len_q <= lo_hold_len_d;
         lo_val_q      <= lo_val_d;
         lo_len_q      <= lo_len_d;
         hi_val_q      <= hi_val_d;
         hi_len_q      <= hi_len_d;
         out_valid_q   <= out_valid_d;
         err_q         <= err_d;
      end
   end

endmodule

// File: doc/range_parser.md
Name: range_parser

Overview:
- Sequential front-end stage that sits directly upstream of the min/max length-adjust stage.
- Consumes an ASCII byte stream of ranges in the form "lo-hi," with terminator ',' or LF, e.g. "11-22,95-115\n".
- For each range it produces the binary lo/hi values and their decimal digit counts; these feed the adjust stage's value and length inputs (lo with minMaxSel=0, hi with minMaxSel=1).
- Malformed ranges are flagged and dropped, never emitted.

Parameters:
- W, 32, width of the lo/hi value outputs.
- LW, 4, width of the digit-length outputs.
- MAX_DIGITS, 10, maximum significant decimal digits accepted per field.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_byte  input  8  ASCII character.
- in_valid  input  1  in_byte is valid.
- in_ready  output  1  parser accepts in_byte this cycle.
- lo_val  output  W  binary value of the range low bound.
- lo_len  output  LW  significant decimal digits of lo_val.
- hi_val  output  W  binary value of the range high bound.
- hi_len  output  LW  significant decimal digits of hi_val.
- out_valid  output  1  range outputs valid; held until accepted.
- out_ready  input  1  downstream accepts the range.
- err  output  1  one-cycle pulse when a malformed range is dropped.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=LO; lo_val, hi_val, lo_len, hi_len =0; out_valid=0; err=0; in_ready=1; accumulators and seen-flags cleared. Reset takes priority over everything, including mid-field or a pending emit; no output is produced for a partial range.
- Byte transfer: occurs when in_valid && in_ready. in_ready = 1 in states LO, HI and SKIP; in_ready = 0 in state EMIT.
- Digit update ('0'..'9' in LO or HI):
  - acc <= acc*10 + digit, computed at W+4 bits.
  - If acc != 0 or digit != 0, len <= len+1. Leading zeros are not counted.
  - The field is marked seen.
- LO state:
  - digit: accumulate as above.
  - '-' with the field seen: latch lo_acc/lo_len, then go to HI.
  - '-' with the field not seen: error.
  - ',' or LF with nothing seen: ignored (empty line or double comma); stay in LO, no err.
  - ',' or LF with the field seen: error (range has no hi).
  - Any other byte: error.
- HI state:
  - digit: accumulate as above.
  - ',' or LF with the field seen: go to EMIT. lo/hi outputs are registered that cycle and out_valid=1 on the next cycle, i.e. 1-cycle latency from the terminator.
  - ',' or LF with the field not seen: error.
  - '-' or any other byte: error.
- Zero field: a field of only zeros has value 0 and len=1.
- Overflow: if the W+4-bit result exceeds 2^W-1, or len would exceed MAX_DIGITS, an error is raised immediately on that byte.
- Error handling: err pulses for exactly one cycle, the same cycle the state enters SKIP. Accumulators are cleared. SKIP discards bytes up to and including the next ',' or LF, then returns to LO. A terminator that itself causes an error returns directly to LO with the err pulse.
- EMIT state:
  - out_valid=1 and outputs are stable until out_valid && out_ready.
  - On that handshake: out_valid drops the next cycle, accumulators clear, state returns to LO.
  - Input is stalled (in_ready=0) throughout EMIT, so a back-to-back range costs at least one bubble cycle.
- Outputs hold their last emitted values while out_valid=0.
- hi < lo is not checked; it is passed through unchanged.

Test Plan:
- Reset mid-stream: feed "12-3", assert rst_n=0 for 1 cycle, then feed "5-7," -> single output lo_val=5, lo_len=1, hi_val=7, hi_len=1; out_valid rises 1 cycle after ',' is accepted.
- Basic two ranges "11-22,95-115\n" with out_ready=1 -> (11,2,22,2) then (95,2,115,3). in_ready=0 during each EMIT cycle; no err.
- Backpressure: "998-1012," with out_ready=0 for 5 cycles -> out_valid held with lo=998/3, hi=1012/4 stable; in_ready=0 throughout; the next byte is accepted only after the handshake.
- Leading zeros and max width: "007-4294967295," -> lo_val=7, lo_len=1, hi_val=4294967295, hi_len=10. "0-0," -> (0,1,0,1).
- Overflow: "1-4294967296,3-4," -> err pulse on the final '6', remainder skipped; then (3,1,4,1) emitted.
- Malformed and empty input: ",,\n-5,12,a-3,8-9," -> commas/LF ignored silently; err pulses for "-5", "12" and "a-3" (3 pulses total); only (8,1,9,1) emitted.
